if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline (pipecomp): owns the PC, drives the

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 120 ++++++++++++
 tb/tb_if_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: reset/halt/bubble encodings, FSM states and the IF/ID record.
// The ID stage and the hazard unit import the same package.
package if_stage_pkg;

    localparam int          XLEN           = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

    // Redirect targets are word addresses; the two low bits are dropped, not trapped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage boundary: ID/hazard controls, instruction-ROM port and the IF/ID register view.
interface if_stage_if;

    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall, flush, br_taken, br_target, jmp, jmp_target, imem_rdata,
        output imem_addr, PC, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, fetch_cnt
    );

    modport slave (
        output stall, flush, br_taken, br_target, jmp, jmp_target, imem_rdata,
        input  imem_addr, PC, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, halted, fetch_cnt
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: hold when disabled, load a bubble on clear, else capture the fetch record.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   enable,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t BUBBLE = '{pc: 32'h0000_0000, pc4: 32'h0000_0000,
                                  instr: NOP_INSTR, valid: 1'b0};

    if_id_t q_r;

    // Pipeline register with async reset to a bubble; a stalled stage keeps its contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r <= BUBBLE;
        end else if (enable) begin
            if (clear) begin
                q_r <= BUBBLE;
            end else begin
                q_r <= d;
            end
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC ownership, next-PC selection, IF/ID register and halt detection.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    if_stage_if.master    bus
);

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  fetch_cnt_r;
    logic         halted_r;

    logic [31:0]  pc_plus4_s;
    logic [31:0]  pc_next_s;
    logic         halt_hit_s;
    logic         deliver_s;
    logic         ifid_en_s;
    logic         ifid_clr_s;
    if_id_t       ifid_d_s;
    if_id_t       ifid_q_s;

    assign pc_plus4_s = pc_r + 32'd4;

    // Per-edge fetch decision. Outside RUN the register only ever takes bubbles and PC holds.
    always_comb begin
        pc_next_s  = pc_r;
        halt_hit_s = 1'b0;
        deliver_s  = 1'b0;
        ifid_en_s  = 1'b1;
        ifid_clr_s = 1'b1;
        ifid_d_s   = '{pc: pc_r, pc4: pc_plus4_s, instr: bus.imem_rdata, valid: 1'b0};
        case (state_r)
            ST_RUN: begin
                ifid_en_s  = ~bus.stall;
                ifid_clr_s = bus.flush | bus.jmp | bus.br_taken;
                if (bus.stall) begin
                    pc_next_s = pc_r;
                end else if (bus.jmp) begin
                    pc_next_s = word_align(bus.jmp_target);
                end else if (bus.br_taken) begin
                    pc_next_s = word_align(bus.br_target);
                end else if (bus.flush) begin
                    pc_next_s = pc_plus4_s;
                end else if (bus.imem_rdata == HALT_INSTR) begin
                    // The halt word is latched as an invalid record so it never executes.
                    halt_hit_s = 1'b1;
                    pc_next_s  = pc_r;
                end else begin
                    deliver_s = 1'b1;
                    pc_next_s = pc_plus4_s;
                end
                ifid_d_s.valid = deliver_s;
            end
            default: begin
                pc_next_s = pc_r;
            end
        endcase
    end

    // Fetch FSM with PC, halt flag and delivered-instruction counter as registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_BOOT;
            pc_r        <= RESET_PC;
            halted_r    <= 1'b0;
            fetch_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    pc_r <= pc_next_s;
                    if (deliver_s) begin
                        fetch_cnt_r <= fetch_cnt_r + 32'd1;
                    end
                    if (halt_hit_s) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    halted_r <= 1'b1;
                end
                default: begin
                    // An illegal encoding freezes fetch rather than running from an unknown PC.
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .rstn   (rstn),
        .enable (ifid_en_s),
        .clear  (ifid_clr_s),
        .d      (ifid_d_s),
        .q      (ifid_q_s)
    );

    assign bus.imem_addr   = pc_r;
    assign bus.PC          = pc_r;
    assign bus.if_id_pc    = ifid_q_s.pc;
    assign bus.if_id_pc4   = ifid_q_s.pc4;
    assign bus.if_id_instr = ifid_q_s.instr;
    assign bus.if_id_valid = ifid_q_s.valid;
    assign bus.halted      = halted_r;
    assign bus.fetch_cnt   = fetch_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch scenarios followed by randomized control traffic,
// all compared against a cycle-level reference model of the fetch rules.
module tb_if_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    if_stage_if bus ();

    logic [31:0] rom [64];
    assign bus.imem_rdata = rom[bus.imem_addr[7:2]];

    if_stage dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [31:0] m_pc, m_cnt, m_ipc, m_ipc4, m_iinstr;
    logic        m_ivalid, m_booted, m_halted;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic m_bubble();
        m_ipc = 32'd0; m_ipc4 = 32'd0; m_iinstr = NOP; m_ivalid = 1'b0;
    endtask

    task automatic m_reset();
        m_pc = 32'd0; m_cnt = 32'd0; m_booted = 1'b0; m_halted = 1'b0;
        m_bubble();
    endtask

    // One rising edge of the fetch stage, expressed as the architectural rules.
    task automatic m_step(input bit s, input bit f, input bit b, input logic [31:0] bt,
                          input bit j, input logic [31:0] jt);
        logic [31:0] word;
        word = rom[m_pc[7:2]];
        if (!m_booted) begin
            m_booted = 1'b1;
            m_bubble();
        end else if (m_halted) begin
            m_bubble();
        end else if (!s) begin
            if (j) begin
                m_bubble(); m_pc = {jt[31:2], 2'b00};
            end else if (b) begin
                m_bubble(); m_pc = {bt[31:2], 2'b00};
            end else if (f) begin
                m_bubble(); m_pc = m_pc + 32'd4;
            end else if (word == HALT) begin
                m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_iinstr = word; m_ivalid = 1'b0;
                m_halted = 1'b1;
            end else begin
                m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_iinstr = word; m_ivalid = 1'b1;
                m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_all();
        chk("pc",          bus.PC,                 m_pc);
        chk("imem_addr",   bus.imem_addr,          m_pc);
        chk("if_id_pc",    bus.if_id_pc,           m_ipc);
        chk("if_id_pc4",   bus.if_id_pc4,          m_ipc4);
        chk("if_id_instr", bus.if_id_instr,        m_iinstr);
        chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_ivalid});
        chk("halted",      {31'd0, bus.halted},    {31'd0, m_halted});
        chk("fetch_cnt",   bus.fetch_cnt,          m_cnt);
    endtask

    // Entered just after a falling edge; drives one cycle of inputs and checks after the edge.
    task automatic cycle(input bit s, input bit f, input bit b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt);
        bus.stall = s; bus.flush = f; bus.br_taken = b; bus.br_target = bt;
        bus.jmp = j; bus.jmp_target = jt;
        @(posedge clk);
        m_step(s, f, b, bt, j, jt);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Asserted just after a falling edge, held 20ns, released on a falling edge.
    task automatic do_reset();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_pc",        bus.PC,                   32'd0);
        chk("rst_valid",     {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst_fetch_cnt", bus.fetch_cnt,            32'd0);
        chk("rst_halted",    {31'd0, bus.halted},      32'd0);
        #19;
        rstn = 1'b1;
        m_reset();
        check_all();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0000_0020;
        return w;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        return 32'($urandom_range(0, 255));
    endfunction

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0;
        bus.br_target = 32'd0; bus.jmp_target = 32'd0;
        for (int i = 0; i < 64; i++) rom[i] = rand_word();
        rom[0] = 32'h2008_0001; rom[1] = 32'h2009_0002;
        rom[2] = 32'h200A_0003; rom[3] = 32'h200B_0004;
        rom[31] = HALT;
        m_reset();

        // Power-on reset, boot cycle, straight-line fetch and stall
        @(negedge clk);
        do_reset();
        idle();
        chk("boot_bubble", {31'd0, bus.if_id_valid}, 32'd0);
        idle();
        chk("first_valid", {31'd0, bus.if_id_valid}, 32'd1);
        idle();
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("stall_pc",       bus.PC,        32'h0000_0008);
        chk("stall_if_id_pc", bus.if_id_pc,  32'h0000_0004);
        chk("stall_cnt",      bus.fetch_cnt, 32'd2);
        idle();
        chk("release_pc", bus.if_id_pc, 32'h0000_0008);
        idle();
        chk("line_pc",  bus.if_id_pc,  32'h0000_000C);
        chk("line_pc4", bus.if_id_pc4, 32'h0000_0010);
        chk("line_cnt", bus.fetch_cnt, 32'd4);

        // Redirects, priority, stall over redirect, wrap, halt
        cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
        chk("br_pc",     bus.PC, 32'h0000_0040);
        chk("br_bubble", {31'd0, bus.if_id_valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        chk("jmp_wins", bus.PC, 32'h0000_0080);
        idle();
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h20);
        chk("stall_redir_pc",    bus.PC, 32'h0000_0084);
        chk("stall_redir_valid", {31'd0, bus.if_id_valid}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE);
        chk("align_pc", bus.PC, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc",  bus.PC,        32'h0000_0000);
        chk("wrap_pc4", bus.if_id_pc4, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h7C);
        idle();
        chk("halt_flag",  {31'd0, bus.halted}, 32'd1);
        chk("halt_pc",    bus.PC,              32'h0000_007C);
        chk("halt_instr", bus.if_id_instr,     HALT);
        cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        chk("halt_frozen", bus.PC,         32'h0000_007C);
        chk("halt_bubble", bus.if_id_instr, NOP);

        // Randomized episodes, each opened by a mid-run reset
        for (int ep = 0; ep < 24; ep++) begin
            for (int i = 0; i < 64; i++) rom[i] = rand_word();
            if ($urandom_range(0, 1) == 1) rom[$urandom_range(4, 63)] = HALT;
            do_reset();
            for (int c = 0; c < 150; c++) begin
                cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 10, rand_target(),
                      $urandom_range(0, 99) < 8,  rand_target());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
